signed_sat_accumulator: RTL

//  Multi-channel signed accumulator. Each accepted sample is added to the

---
 rtl/signed_sat_pkg.sv | 34 +++
 rtl/signed_add_sat_core.sv | 24 ++
 rtl/signed_sat_accumulator.sv | 114 +++++++++++
 3 files changed

// File: rtl/signed_sat_pkg.sv
// Shared saturation helpers for the signed accumulator datapath.
// Arithmetic is done on a 64-bit signed carrier so one function serves every width.
package signed_sat_pkg;

    typedef logic signed [63:0] wide_t;

    typedef struct packed {
        logic  ovf;
        wide_t result;
    } sat_res_t;

    function automatic wide_t sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic wide_t sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // a and b must already be sign-extended w-bit values; result is exact before clamping.
    function automatic sat_res_t sat_add(input wide_t a, input wide_t b, input int w, input logic mode);
        wide_t    s;
        sat_res_t r;
        s     = a + b;
        r.ovf = (s > sat_max(w)) || (s < sat_min(w));
        if (mode && r.ovf) begin
            r.result = s[63] ? sat_min(w) : sat_max(w);
        end else begin
            r.result = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/signed_add_sat_core.sv
// Combinational ACC_W-bit signed adder with selectable saturate/wrap behaviour.
module signed_add_sat_core
    import signed_sat_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    input  logic             sat_mode,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    sat_res_t res_s;

    // Widen both operands and let the package helper decide clamp vs wrap.
    always_comb begin
        res_s = sat_add(64'(signed'(a)), 64'(signed'(b)), ACC_W, sat_mode);
    end

    assign sum = ACC_W'(res_s.result);
    assign ovf = res_s.ovf;

endmodule

// File: rtl/signed_sat_accumulator.sv
// Multi-channel signed accumulator with per-sample saturate/wrap and sticky overflow.
// One shared adder feeds the channel register array; results appear one cycle later.
module signed_sat_accumulator #(
    parameter  int IN_W  = 4,
    parameter  int ACC_W = 8,
    parameter  int N_CH  = 4,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_clear,
    input  logic              sat_mode,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic [N_CH-1:0]   ovf_sticky
);

    localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);

    logic [ACC_W-1:0] acc_r [N_CH];
    logic [N_CH-1:0]  ovf_sticky_r;
    logic             out_valid_r;
    logic [CH_W-1:0]  out_ch_r;
    logic [ACC_W-1:0] out_sum_r;
    logic             out_ovf_r;

    logic             ch_ok_s;
    logic [ACC_W-1:0] acc_rd_s;
    logic [ACC_W-1:0] add_a_s;
    logic [ACC_W-1:0] add_b_s;
    logic [ACC_W-1:0] sum_s;
    logic             ovf_s;

    assign ch_ok_s = ({1'b0, in_ch} < N_CH_L);
    assign add_b_s = ACC_W'(signed'(in_data));

    // Select the addressed channel's running sum without indexing past the array.
    always_comb begin
        acc_rd_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            acc_rd_s = (in_ch == CH_W'(i)) ? acc_r[i] : acc_rd_s;
        end
    end

    // A clear in the same cycle as a sample restarts the channel from zero.
    always_comb begin
        if (in_clear) begin
            add_a_s = '0;
        end else begin
            add_a_s = acc_rd_s;
        end
    end

    signed_add_sat_core #(
        .ACC_W (ACC_W)
    ) u_core (
        .a        (add_a_s),
        .b        (add_b_s),
        .sat_mode (sat_mode),
        .sum      (sum_s),
        .ovf      (ovf_s)
    );

    // Channel state: accumulate, clear, or clear-then-load the addressed channel only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                acc_r[i] <= '0;
            end
            ovf_sticky_r <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_ok_s && (in_ch == CH_W'(i))) begin
                    if (in_valid) begin
                        acc_r[i]        <= sum_s;
                        ovf_sticky_r[i] <= (in_clear ? 1'b0 : ovf_sticky_r[i]) | ovf_s;
                    end else if (in_clear) begin
                        acc_r[i]        <= '0;
                        ovf_sticky_r[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Result stage: pulses valid for accepted samples, otherwise holds the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_ch_r    <= '0;
            out_sum_r   <= '0;
            out_ovf_r   <= 1'b0;
        end else if (in_valid && ch_ok_s) begin
            out_valid_r <= 1'b1;
            out_ch_r    <= in_ch;
            out_sum_r   <= sum_s;
            out_ovf_r   <= ovf_s;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_ch     = out_ch_r;
    assign out_sum    = out_sum_r;
    assign out_ovf    = out_ovf_r;
    assign ovf_sticky = ovf_sticky_r;

endmodule
